// File: rtl/hazard_fw_ctrl_pkg.sv
// Shared types for the EX-stage forwarding controller.
//   fw_stage_t / fw_regs_t / fw_cntrl_bus_t : forwarding decision carried to EX
//   bypass_bus_t                            : forwarded operand value
//   stall_cause_t                           : reason for the current hold state
//   inflight_slot_t                         : one in-flight register writer
//   fsm_state_t                             : hazard FSM state encoding
package hazard_fw_ctrl_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    NONE_STAGE = 2'd0,
    MEM_STAGE  = 2'd1,
    WB_STAGE   = 2'd2
  } fw_stage_t;

  typedef enum logic [1:0] {
    RS_NONE = 2'd0,
    RS1     = 2'd1,
    RS2     = 2'd2,
    RS_BOTH = 2'd3
  } fw_regs_t;

  typedef struct packed {
    fw_stage_t stage;
    fw_regs_t  regs;
  } fw_cntrl_bus_t;

  typedef struct packed {
    logic [XLEN-1:0] rd;
  } bypass_bus_t;

  typedef enum logic [1:0] {
    NO_STALL = 2'd0,
    LOAD_USE = 2'd1,
    SPLIT    = 2'd2
  } stall_cause_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              is_load;
  } inflight_slot_t;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    HOLD_LU    = 2'd1,
    HOLD_SPLIT = 2'd2
  } fsm_state_t;

  localparam fw_cntrl_bus_t FW_NONE = '{stage: NONE_STAGE, regs: RS_NONE};

  function automatic fw_regs_t regs_of(input logic hit_rs1, input logic hit_rs2);
    fw_regs_t r;
    case ({hit_rs1, hit_rs2})
      2'b11:   r = RS_BOTH;
      2'b10:   r = RS1;
      2'b01:   r = RS2;
      default: r = RS_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hazard_fw_ctrl_match.sv
// Combinational comparator of the ID source registers against one in-flight slot.
//   slot_i              : in-flight writer {valid, rd, is_load}
//   rs1_i / rs2_i       : ID source addresses
//   use_rs1_i/use_rs2_i : ID instruction actually reads that source
//   hit_rs1_o/hit_rs2_o : source is produced by this slot
//   is_load_o           : the slot's producer is a load
module hazard_match
  import hazard_fw_ctrl_pkg::*;
(
  input  inflight_slot_t    slot_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic              use_rs1_i,
  input  logic              use_rs2_i,
  output logic              hit_rs1_o,
  output logic              hit_rs2_o,
  output logic              is_load_o
);

  logic live;

  // x0 is hardwired; never treat it as produced even if a slot carries rd=0.
  assign live      = slot_i.valid && (slot_i.rd != '0);
  assign hit_rs1_o = live && use_rs1_i && (rs1_i == slot_i.rd);
  assign hit_rs2_o = live && use_rs2_i && (rs2_i == slot_i.rd);
  assign is_load_o = slot_i.is_load;

endmodule

// File: rtl/hazard_fw_ctrl.sv
// Forwarding / hazard controller for the EX operand selector.
// Tracks the writers in EX and MEM, decides per ID instruction whether rs1/rs2
// are bypassed and from which stage, and stalls on load-use and on the
// split-producer case (the bypass bus carries a single value).
//   clk_i, rst_ni        : clock, async active-low reset
//   id_*                 : instruction currently in ID
//   flush_i              : kill the ID instruction (redirect from EX)
//   stall_ext_i          : freeze the whole pipe, every register holds
//   mem_result_i         : result of the instruction in MEM
//   wb_result_i          : result of the instruction in WB
//   fw_cntrl_o           : registered forwarding decision, aligned with EX
//   bypass_o             : forwarded value selected by fw_cntrl_o
//   stall_o              : hold PC/ID, bubble into EX
//   stall_cause_o        : cause of the current FSM hold state
//   stall_cnt_o          : saturating count of stall cycles
module hazard_fw_ctrl
  import hazard_fw_ctrl_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   id_valid_i,
  input  logic [REG_AW-1:0]      id_rs1_i,
  input  logic [REG_AW-1:0]      id_rs2_i,
  input  logic                   id_use_rs1_i,
  input  logic                   id_use_rs2_i,
  input  logic [REG_AW-1:0]      id_rd_i,
  input  logic                   id_we_i,
  input  logic                   id_is_load_i,
  input  logic                   flush_i,
  input  logic                   stall_ext_i,
  input  logic [XLEN-1:0]        mem_result_i,
  input  logic [XLEN-1:0]        wb_result_i,
  output fw_cntrl_bus_t          fw_cntrl_o,
  output bypass_bus_t            bypass_o,
  output logic                   stall_o,
  output stall_cause_t           stall_cause_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  inflight_slot_t         ex_slot_q, mem_slot_q, ex_slot_d;
  fw_cntrl_bus_t          fw_q, fw_d;
  fsm_state_t             state_q;
  stall_cause_t           cause_q;
  logic [STALL_CNT_W-1:0] cnt_q;

  logic ex_h1, ex_h2, ex_ld;
  logic mem_h1, mem_h2, mem_ld_unused;
  logic rs1_ex, rs2_ex, rs1_mem, rs2_mem;
  logic any_ex, any_mem;
  logic load_use, split, issue;

  hazard_match u_match_ex (
    .slot_i    (ex_slot_q),
    .rs1_i     (id_rs1_i),
    .rs2_i     (id_rs2_i),
    .use_rs1_i (id_use_rs1_i),
    .use_rs2_i (id_use_rs2_i),
    .hit_rs1_o (ex_h1),
    .hit_rs2_o (ex_h2),
    .is_load_o (ex_ld)
  );

  hazard_match u_match_mem (
    .slot_i    (mem_slot_q),
    .rs1_i     (id_rs1_i),
    .rs2_i     (id_rs2_i),
    .use_rs1_i (id_use_rs1_i),
    .use_rs2_i (id_use_rs2_i),
    .hit_rs1_o (mem_h1),
    .hit_rs2_o (mem_h2),
    .is_load_o (mem_ld_unused)
  );

  // Youngest producer wins: a mem_slot hit only counts if ex_slot missed.
  assign rs1_ex  = ex_h1;
  assign rs2_ex  = ex_h2;
  assign rs1_mem = mem_h1 && !ex_h1;
  assign rs2_mem = mem_h2 && !ex_h2;
  assign any_ex  = rs1_ex || rs2_ex;
  assign any_mem = rs1_mem || rs2_mem;

  // Each source resolves to at most one slot, so hits in both slots means
  // rs1 and rs2 need two different producers.
  assign load_use = id_valid_i && any_ex && ex_ld;
  assign split    = id_valid_i && any_ex && any_mem;
  assign stall_o  = (load_use || split) && !flush_i;
  assign issue    = id_valid_i && !stall_o && !flush_i;

  always_comb begin
    fw_d = FW_NONE;
    if (issue) begin
      if (any_ex) begin
        fw_d.stage = MEM_STAGE;
        fw_d.regs  = regs_of(rs1_ex, rs2_ex);
      end else if (any_mem) begin
        fw_d.stage = WB_STAGE;
        fw_d.regs  = regs_of(rs1_mem, rs2_mem);
      end
    end
  end

  always_comb begin
    ex_slot_d         = '0;
    ex_slot_d.valid   = issue && id_we_i && (id_rd_i != '0);
    ex_slot_d.rd      = id_rd_i;
    ex_slot_d.is_load = id_is_load_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_slot_q  <= '0;
      mem_slot_q <= '0;
      fw_q       <= FW_NONE;
      state_q    <= RUN;
      cause_q    <= NO_STALL;
      cnt_q      <= '0;
    end else if (!stall_ext_i) begin
      ex_slot_q  <= ex_slot_d;
      mem_slot_q <= ex_slot_q;
      fw_q       <= fw_d;
      if (stall_o && (cnt_q != '1)) cnt_q <= cnt_q + STALL_CNT_W'(1);
      // Load-use takes priority: a younger load must reach MEM before it can
      // be forwarded at all.
      case (state_q)
        RUN: begin
          if (stall_o && load_use) begin
            state_q <= HOLD_LU;
            cause_q <= LOAD_USE;
          end else if (stall_o) begin
            state_q <= HOLD_SPLIT;
            cause_q <= SPLIT;
          end
        end
        HOLD_LU, HOLD_SPLIT: begin
          state_q <= RUN;
          cause_q <= NO_STALL;
        end
        default: begin
          state_q <= RUN;
          cause_q <= NO_STALL;
        end
      endcase
    end
  end

  always_comb begin
    bypass_o = '0;
    case (fw_q.stage)
      MEM_STAGE: bypass_o.rd = mem_result_i;
      WB_STAGE:  bypass_o.rd = wb_result_i;
      default:   bypass_o.rd = '0;
    endcase
  end

  assign fw_cntrl_o    = fw_q;
  assign stall_cause_o = cause_q;
  assign stall_cnt_o   = cnt_q;

endmodule

// File: tb/tb_hazard_fw_ctrl.sv
module tb_hazard_fw_ctrl;
  import hazard_fw_ctrl_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              id_valid_i = 1'b0;
  logic [4:0]        id_rs1_i = '0;
  logic [4:0]        id_rs2_i = '0;
  logic              id_use_rs1_i = 1'b0;
  logic              id_use_rs2_i = 1'b0;
  logic [4:0]        id_rd_i = '0;
  logic              id_we_i = 1'b0;
  logic              id_is_load_i = 1'b0;
  logic              flush_i = 1'b0;
  logic              stall_ext_i = 1'b0;
  logic [XLEN-1:0]   mem_result_i = 32'h0000_1234;
  logic [XLEN-1:0]   wb_result_i = 32'hDEAD_BEEF;
  fw_cntrl_bus_t     fw_cntrl_o;
  bypass_bus_t       bypass_o;
  logic              stall_o;
  stall_cause_t      stall_cause_o;
  logic [15:0]       stall_cnt_o;

  int n_chk = 0;
  int n_err = 0;

  hazard_fw_ctrl #(.STALL_CNT_W(16)) u_dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_use_rs1_i  (id_use_rs1_i),
    .id_use_rs2_i  (id_use_rs2_i),
    .id_rd_i       (id_rd_i),
    .id_we_i       (id_we_i),
    .id_is_load_i  (id_is_load_i),
    .flush_i       (flush_i),
    .stall_ext_i   (stall_ext_i),
    .mem_result_i  (mem_result_i),
    .wb_result_i   (wb_result_i),
    .fw_cntrl_o    (fw_cntrl_o),
    .bypass_o      (bypass_o),
    .stall_o       (stall_o),
    .stall_cause_o (stall_cause_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present one instruction in ID, then let combinational outputs settle.
  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld);
    id_valid_i   = v;
    id_rs1_i     = rs1;
    id_rs2_i     = rs2;
    id_use_rs1_i = u1;
    id_use_rs2_i = u2;
    id_rd_i      = rd;
    id_we_i      = we;
    id_is_load_i = ld;
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_fw(input string tag, input fw_stage_t st, input fw_regs_t rg);
    chk({tag, "_stage"}, 32'(fw_cntrl_o.stage), 32'(st));
    chk({tag, "_regs"}, 32'(fw_cntrl_o.regs), 32'(rg));
  endtask

  initial begin
    #12;
    // reset state
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk_fw("rst_fw", NONE_STAGE, RS_NONE);
    chk("rst_bypass", bypass_o.rd, 32'd0);
    chk("rst_cause", 32'(stall_cause_o), 32'(NO_STALL));
    chk("rst_cnt", 32'(stall_cnt_o), 32'd0);
    rst_ni = 1'b1;
    idle(2);

    // add x5 ; add x6,x5,x1 -> forward from MEM on rs1
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    chk("alu_stall", 32'(stall_o), 32'd0);
    step();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk_fw("alu_fw", MEM_STAGE, RS1);
    chk("alu_bypass", bypass_o.rd, 32'h0000_1234);
    idle(2);

    // lw x7 ; add x8,x7,x7 -> load-use stall, freeze 3 cycles in HOLD_LU
    drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    chk("lu_stall", 32'(stall_o), 32'd1);
    step();
    chk("lu_stall_rel", 32'(stall_o), 32'd0);
    chk("lu_cause", 32'(stall_cause_o), 32'(LOAD_USE));
    chk("lu_cnt", 32'(stall_cnt_o), 32'd1);
    chk_fw("lu_fw_bubble", NONE_STAGE, RS_NONE);
    stall_ext_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_cause", 32'(stall_cause_o), 32'(LOAD_USE));
      chk("frz_cnt", 32'(stall_cnt_o), 32'd1);
      chk("frz_fw_stage", 32'(fw_cntrl_o.stage), 32'(NONE_STAGE));
      chk("frz_stall", 32'(stall_o), 32'd0);
    end
    stall_ext_i = 1'b0;
    step();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk_fw("lu_fw", WB_STAGE, RS_BOTH);
    chk("lu_bypass", bypass_o.rd, 32'hDEAD_BEEF);
    chk("lu_cause_run", 32'(stall_cause_o), 32'(NO_STALL));
    chk("lu_cnt_after", 32'(stall_cnt_o), 32'd1);
    idle(2);

    // add x1 ; add x2 ; sub x3,x1,x2 -> split stall, then younger (x2) from WB
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    chk("sp_stall", 32'(stall_o), 32'd1);
    step();
    chk("sp_cause", 32'(stall_cause_o), 32'(SPLIT));
    chk("sp_stall_rel", 32'(stall_o), 32'd0);
    chk("sp_cnt", 32'(stall_cnt_o), 32'd2);
    step();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk_fw("sp_fw", WB_STAGE, RS2);
    chk("sp_bypass", bypass_o.rd, 32'hDEAD_BEEF);
    idle(2);

    // addi x0 ; add x9,x0,x0 -> x0 never forwarded
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    chk("x0_stall", 32'(stall_o), 32'd0);
    step();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk_fw("x0_fw", NONE_STAGE, RS_NONE);
    chk("x0_bypass", bypass_o.rd, 32'd0);
    idle(2);

    // add x4 ; add x4 ; add x10,x4,x4 -> youngest wins, no split
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    chk("yw_stall", 32'(stall_o), 32'd0);
    step();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk_fw("yw_fw", MEM_STAGE, RS_BOTH);
    idle(2);

    // load-use with flush in the same cycle -> no stall, FSM stays RUN
    drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
    flush_i = 1'b1;
    #1;
    chk("fl_stall", 32'(stall_o), 32'd0);
    step();
    flush_i = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk_fw("fl_fw", NONE_STAGE, RS_NONE);
    chk("fl_cause", 32'(stall_cause_o), 32'(NO_STALL));
    chk("fl_cnt", 32'(stall_cnt_o), 32'd2);
    idle(2);

    // reset asserted mid HOLD_LU -> immediate reset values
    drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
    step();
    drive(1'b1, 5'd0, 5'd7, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
    chk("rm_stall", 32'(stall_o), 32'd1);
    step();
    chk("rm_cause_pre", 32'(stall_cause_o), 32'(LOAD_USE));
    chk("rm_cnt_pre", 32'(stall_cnt_o), 32'd3);
    drive(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    step();
    chk_fw("rm_fw_pre", WB_STAGE, RS_BOTH);
    rst_ni = 1'b0;
    #1;
    chk_fw("rm_fw", NONE_STAGE, RS_NONE);
    chk("rm_cause", 32'(stall_cause_o), 32'(NO_STALL));
    chk("rm_cnt", 32'(stall_cnt_o), 32'd0);
    chk("rm_bypass", bypass_o.rd, 32'd0);
    #1;
    rst_ni = 1'b1;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
